// File: rtl/tff_toggle_arbiter.sv
// rtl/tff_toggle_arbiter.sv - round-robin arbiter feeding a shared toggle bank
// with per-bit lock windows.
module tff_toggle_arbiter #(
   parameter int NREQ  = 4,
   parameter int GIDW  = 2,
   parameter int NBITS = 8,
   parameter int IDXW  = 3,
   parameter int HOLD  = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*IDXW-1:0] req_idx,
   output logic [NREQ-1:0]      req_ready,
   input  logic                 clear,
   output logic [NBITS-1:0]     q,
   output logic [NBITS-1:0]     t_out,
   output logic [NBITS-1:0]     locked,
   output logic                 grant_valid,
   output logic [GIDW-1:0]      grant_id,
   output logic                 err
);

   localparam int CW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
   localparam logic [CW-1:0] HOLD_C = CW'(HOLD);

   logic [CW-1:0]    cnt     [NBITS];
   logic [CW-1:0]    cnt_nxt [NBITS];
   logic [NBITS-1:0] locked_nxt;
   logic [NBITS-1:0] sel     [NREQ];
   logic [NREQ-1:0]  in_rng;
   logic [NREQ-1:0]  elig;
   logic [GIDW-1:0]  ptr;
   logic [GIDW-1:0]  win;
   logic [GIDW-1:0]  ptr_nxt;
   logic [NBITS-1:0] win_sel;
   logic             win_inr;
   logic             found;
   logic             xfer;
   int               scan_j;

   // An out-of-range index decodes to an all-zero select, so it can never be locked.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         sel[i] = '0;
         for (int b = 0; b < NBITS; b++) begin
            if (int'(req_idx[i*IDXW +: IDXW]) == b) sel[i][b] = 1'b1;
         end
         in_rng[i] = |sel[i];
         elig[i]   = req_valid[i] && ((sel[i] & locked) == '0);
      end
   end

   always_comb begin
      found  = 1'b0;
      win    = '0;
      scan_j = 0;
      for (int k = 0; k < NREQ; k++) begin
         scan_j = (int'(ptr) + k) % NREQ;
         if (!found && elig[scan_j]) begin
            found = 1'b1;
            win   = GIDW'(scan_j);
         end
      end
      req_ready = '0;
      if (found && reset_n && !clear) req_ready[win] = 1'b1;
   end

   assign xfer    = |(req_valid & req_ready);
   assign win_sel = sel[win];
   assign win_inr = in_rng[win];
   assign ptr_nxt = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;

   // A fresh toggle reloads its counter, overriding the decrement.
   always_comb begin
      for (int b = 0; b < NBITS; b++) begin
         cnt_nxt[b] = (cnt[b] != '0) ? cnt[b] - CW'(1) : '0;
         if (xfer && win_sel[b]) cnt_nxt[b] = HOLD_C;
         locked_nxt[b] = (cnt_nxt[b] != '0);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q           <= '0;
         t_out       <= '0;
         locked      <= '0;
         grant_valid <= 1'b0;
         grant_id    <= '0;
         err         <= 1'b0;
         ptr         <= '0;
         for (int b = 0; b < NBITS; b++) cnt[b] <= '0;
      end else if (clear) begin
         q           <= '0;
         t_out       <= '0;
         locked      <= '0;
         grant_valid <= 1'b0;
         err         <= 1'b0;
         for (int b = 0; b < NBITS; b++) cnt[b] <= '0;
      end else begin
         grant_valid <= xfer;
         t_out       <= '0;
         err         <= 1'b0;
         locked      <= locked_nxt;
         for (int b = 0; b < NBITS; b++) cnt[b] <= cnt_nxt[b];
         if (xfer) begin
            grant_id <= win;
            ptr      <= ptr_nxt;
            if (win_inr) begin
               q     <= q ^ win_sel;
               t_out <= win_sel;
            end else begin
               err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// tb/tb_tff_toggle_arbiter.sv - scoreboard bench for tff_toggle_arbiter
module tb_tff_toggle_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [11:0] req_idx = '0;
   logic [3:0]  req_ready;
   logic        clear = 1'b0;
   logic [7:0]  q, t_out, locked;
   logic        grant_valid;
   logic [1:0]  grant_id;
   logic        err;

   logic [3:0]  v6 = '0;
   logic [11:0] idx6 = '0;
   logic [3:0]  ready6;
   logic [5:0]  q6, t6, l6;
   logic        gv6;
   logic [1:0]  gid6;
   logic        err6;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic prev_g = 1'b0;

   typedef struct {
      int         cyc;
      logic [1:0] gid;
      logic [7:0] q;
      logic [7:0] t;
      logic [7:0] l;
   } exp_t;
   exp_t sb[$];

   tff_toggle_arbiter #(.NREQ(4), .GIDW(2), .NBITS(8), .IDXW(3), .HOLD(2)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_idx(req_idx),
      .req_ready(req_ready), .clear(clear), .q(q), .t_out(t_out), .locked(locked),
      .grant_valid(grant_valid), .grant_id(grant_id), .err(err)
   );

   tff_toggle_arbiter #(.NREQ(4), .GIDW(2), .NBITS(6), .IDXW(3), .HOLD(2)) dut6 (
      .clk(clk), .reset_n(reset_n), .req_valid(v6), .req_idx(idx6),
      .req_ready(ready6), .clear(1'b0), .q(q6), .t_out(t6), .locked(l6),
      .grant_valid(gv6), .grant_id(gid6), .err(err6)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n && grant_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant actual=gid%0d required=none at cycle %0d", grant_id, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("grant_cycle", 32'(cyc), 32'(e.cyc));
            chk("grant_id", 32'(grant_id), 32'(e.gid));
            chk("q", 32'(q), 32'(e.q));
            chk("t_out", 32'(t_out), 32'(e.t));
            chk("locked", 32'(locked), 32'(e.l));
            chk("err", 32'(err), 32'd0);
         end
      end
   end

   task automatic step(input logic [3:0] v, input logic [11:0] idx, input logic clr,
                       input logic [3:0] er, input logic g, input logic [1:0] gid,
                       input logic [7:0] eq, input logic [7:0] et, input logic [7:0] el);
      req_valid = v;
      req_idx   = idx;
      clear     = clr;
      @(negedge clk);
      chk("req_ready", 32'(req_ready), 32'(er));
      if (!prev_g) begin
         chk("idle_grant_valid", 32'(grant_valid), 32'd0);
         chk("idle_t_out", 32'(t_out), 32'd0);
      end
      if (g) sb.push_back('{cyc + 1, gid, eq, et, el});
      prev_g = g;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(4'b0000, 12'd0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      req_valid = 4'b1111;
      req_idx   = {3'd3, 3'd2, 3'd1, 3'd0};
      clear     = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_q", 32'(q), 32'd0);
      chk("rst_t_out", 32'(t_out), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_grant", 32'({grant_valid, grant_id, err}), 32'd0);
      @(posedge clk);
      #1;
      reset_n   = 1'b1;
      req_valid = '0;
      prev_g    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();

      // single toggle, then the held request accepted only after the lock window
      step(4'b0001, 12'd3, 1'b0, 4'b0001, 1'b1, 2'd0, 8'h08, 8'h08, 8'h08);
      idle(3);
      step(4'b0001, 12'd3, 1'b0, 4'b0001, 1'b1, 2'd0, 8'h00, 8'h08, 8'h08);
      step(4'b0001, 12'd3, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
      step(4'b0001, 12'd3, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
      step(4'b0001, 12'd3, 1'b0, 4'b0001, 1'b1, 2'd0, 8'h08, 8'h08, 8'h08);
      idle(3);

      // round robin across all four, then pointer back at 0
      do_reset();
      step(4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 1'b0, 4'b0001, 1'b1, 2'd0, 8'h01, 8'h01, 8'h01);
      step(4'b1110, {3'd3, 3'd2, 3'd1, 3'd0}, 1'b0, 4'b0010, 1'b1, 2'd1, 8'h03, 8'h02, 8'h03);
      step(4'b1100, {3'd3, 3'd2, 3'd1, 3'd0}, 1'b0, 4'b0100, 1'b1, 2'd2, 8'h07, 8'h04, 8'h06);
      step(4'b1000, {3'd3, 3'd2, 3'd1, 3'd0}, 1'b0, 4'b1000, 1'b1, 2'd3, 8'h0F, 8'h08, 8'h0C);
      step(4'b0011, {3'd0, 3'd0, 3'd5, 3'd4}, 1'b0, 4'b0001, 1'b1, 2'd0, 8'h1F, 8'h10, 8'h18);
      step(4'b0010, {3'd0, 3'd0, 3'd5, 3'd4}, 1'b0, 4'b0010, 1'b1, 2'd1, 8'h3F, 8'h20, 8'h30);
      idle(3);

      // same bit requested by req1 and req2 with pointer at 2
      do_reset();
      step(4'b0010, {3'd0, 3'd0, 3'd0, 3'd0}, 1'b0, 4'b0010, 1'b1, 2'd1, 8'h01, 8'h01, 8'h01);
      step(4'b0110, {3'd0, 3'd5, 3'd5, 3'd0}, 1'b0, 4'b0100, 1'b1, 2'd2, 8'h21, 8'h20, 8'h21);
      step(4'b0010, {3'd0, 3'd0, 3'd5, 3'd0}, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
      step(4'b0010, {3'd0, 3'd0, 3'd5, 3'd0}, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
      step(4'b0010, {3'd0, 3'd0, 3'd5, 3'd0}, 1'b0, 4'b0010, 1'b1, 2'd1, 8'h01, 8'h20, 8'h20);
      idle(3);

      // build 8'hA5 with live locks, then clear alongside a request
      do_reset();
      step(4'b0001, 12'd0, 1'b0, 4'b0001, 1'b1, 2'd0, 8'h01, 8'h01, 8'h01);
      step(4'b0001, 12'd2, 1'b0, 4'b0001, 1'b1, 2'd0, 8'h05, 8'h04, 8'h05);
      step(4'b0001, 12'd5, 1'b0, 4'b0001, 1'b1, 2'd0, 8'h25, 8'h20, 8'h24);
      step(4'b0001, 12'd7, 1'b0, 4'b0001, 1'b1, 2'd0, 8'hA5, 8'h80, 8'hA0);
      step(4'b0001, 12'd1, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
      req_valid = '0;
      clear     = 1'b0;
      @(negedge clk);
      chk("clear_q", 32'(q), 32'd0);
      chk("clear_locked", 32'(locked), 32'd0);
      chk("clear_t_out", 32'(t_out), 32'd0);
      chk("clear_grant_valid", 32'(grant_valid), 32'd0);
      @(posedge clk);
      #1;

      // reset mid-hold clears everything without waiting for a clock
      step(4'b0001, 12'd3, 1'b0, 4'b0001, 1'b1, 2'd0, 8'h08, 8'h08, 8'h08);
      req_valid = 4'b0001;
      req_idx   = 12'd4;
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_q", 32'(q), 32'd0);
      chk("async_locked", 32'(locked), 32'd0);
      chk("async_t_out", 32'(t_out), 32'd0);
      chk("async_grant", 32'({grant_valid, grant_id, err}), 32'd0);
      chk("async_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      reset_n   = 1'b1;
      req_valid = '0;
      prev_g    = 1'b0;

      // out-of-range index on the 6-bit bank
      v6   = 4'b0001;
      idx6 = 12'd2;
      @(negedge clk);
      chk("oor_setup_ready", 32'(ready6), 32'b0001);
      @(posedge clk);
      #1;
      v6 = '0;
      @(negedge clk);
      chk("oor_setup_q", 32'(q6), 32'h04);
      repeat (3) @(posedge clk);
      #1;
      v6   = 4'b0001;
      idx6 = 12'd7;
      @(negedge clk);
      chk("oor_ready", 32'(ready6), 32'b0001);
      @(posedge clk);
      #1;
      v6 = '0;
      @(negedge clk);
      chk("oor_err", 32'(err6), 32'd1);
      chk("oor_grant", 32'({gv6, gid6}), 32'b100);
      chk("oor_q", 32'(q6), 32'h04);
      chk("oor_t_out", 32'(t6), 32'd0);
      chk("oor_locked", 32'(l6), 32'd0);
      @(negedge clk);
      chk("oor_err_pulse", 32'(err6), 32'd0);

      @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
